loo_adder_tree: RTL

LOO_ADDER_TREE -- requirements
Module: loo_adder_tree

---
 rtl/loo_adder_tree.sv | 106 ++++++++++
 1 files changed

// File: rtl/loo_adder_tree.sv
// Leave-one-out adder tree: registered binary sum of masked channels, then per-channel total minus self.
// Define LOO_ADDER_TREE_SAT_EN to clamp results to WIDTH bits instead of wrapping.
module loo_adder_tree #(
  parameter int NUM_CH = 6,
  parameter int WIDTH  = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic [NUM_CH-1:0]       i_mask,
  input  logic signed [WIDTH-1:0] i_data [NUM_CH],
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_data [NUM_CH],
  output logic signed [WIDTH-1:0] o_total
);

  localparam int S  = $clog2(NUM_CH);
  localparam int FW = WIDTH + S;

  function automatic int level_cnt(input int lvl);
    return (NUM_CH + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [FW-1:0] v);
`ifdef LOO_ADDER_TREE_SAT_EN
    localparam logic signed [FW-1:0] SMAX = {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [FW-1:0] SMIN = {{(FW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (v > SMAX)      return SMAX[WIDTH-1:0];
    else if (v < SMIN) return SMIN[WIDTH-1:0];
    else               return v[WIDTH-1:0];
`else
    return WIDTH'(v);
`endif
  endfunction

  // Level 0 is the combinational masked input; each later level halves the operand count.
  for (genvar l = 0; l <= S; l++) begin : g_lvl
    localparam int N = level_cnt(l);
    logic signed [FW-1:0] node [N];

    if (l == 0) begin : g_in
      always_comb begin
        for (int k = 0; k < NUM_CH; k++)
          node[k] = i_mask[k] ? FW'(i_data[k]) : '0;
      end
    end else begin : g_add
      localparam int NP = level_cnt(l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_sum
          always_ff @(posedge i_clock) begin
            if (i_reset)
              node[j] <= '0;
            else if (i_enable)
              node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
          end
        end else begin : g_fwd
          always_ff @(posedge i_clock) begin
            if (i_reset)
              node[j] <= '0;
            else if (i_enable)
              node[j] <= g_lvl[l-1].node[2*j];
          end
        end
      end
    end
  end

  logic signed [FW-1:0] xd [S][NUM_CH];
  logic [S-1:0]         vpipe;
  logic signed [FW-1:0] total_full;

  assign total_full = g_lvl[S].node[0];

  // Masked samples and valid travel alongside the tree so they meet the total.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vpipe <= '0;
      for (int s = 0; s < S; s++)
        for (int k = 0; k < NUM_CH; k++)
          xd[s][k] <= '0;
    end else if (i_enable) begin
      vpipe[0] <= i_valid;
      xd[0]    <= g_lvl[0].node;
      for (int s = 1; s < S; s++) begin
        vpipe[s] <= vpipe[s-1];
        xd[s]    <= xd[s-1];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_total <= '0;
      for (int k = 0; k < NUM_CH; k++)
        o_data[k] <= '0;
    end else if (i_enable) begin
      o_valid <= vpipe[S-1];
      o_total <= narrow(total_full);
      for (int k = 0; k < NUM_CH; k++)
        o_data[k] <= narrow(total_full - xd[S-1][k]);
    end
  end

endmodule
